// File: rtl/pov_ram_pkg.sv
// Shared definitions for the POV column-RAM port scheduler: default widths and
// the 2-bit state encoding used by ram_port_sched.
package pov_ram_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD      = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;
  localparam logic [1:0] ST_WR      = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_RD      = ST_RD,
    S_RD_WAIT = ST_RD_WAIT,
    S_WR      = ST_WR
  } sched_state_t;

endpackage

// File: rtl/ram_port_sched.sv
// Clocked read/write scheduler for the single-port POV column RAM; scanner reads win.
// Optional write starvation guard: define POV_SCHED_STARVE_GUARD_EN.
module ram_port_sched
  import pov_ram_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int RD_LAT       = 1,
  parameter int MAX_RD_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          leer_ram
);

  if (RD_LAT < 1 || RD_LAT > 3 || MAX_RD_BURST < 1) begin : g_param_chk
    $error("ram_port_sched: RD_LAT must be 1..3 and MAX_RD_BURST >= 1");
  end

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  sched_state_t  r_state;
  logic [1:0]    r_lat_cnt;
  logic          r_rd_valid;
  logic [DW-1:0] r_rd_data;
  logic          r_wr_ack;
  logic [AW-1:0] r_ram_addr;
  logic          r_ram_we;
  logic [DW-1:0] r_ram_din;
  logic          r_leer_ram;
  logic          w_force_wr;
  logic          w_rd_grant;

`ifdef POV_SCHED_STARVE_GUARD_EN
  localparam int              BW        = $clog2(MAX_RD_BURST + 1);
  localparam logic [BW-1:0]   BURST_MAX = BW'(MAX_RD_BURST);

  logic [BW-1:0] r_rd_burst;

  // A full read burst with a write waiting hands the next slot to the loader.
  assign w_force_wr = wr_req && (r_rd_burst == BURST_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_burst <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_rd_grant) begin
        if (r_rd_burst != BURST_MAX) r_rd_burst <= r_rd_burst + 1'b1;
      end else begin
        r_rd_burst <= '0;
      end
    end
  end
`else
  assign w_force_wr = 1'b0;
`endif

  assign w_rd_grant = rd_req && !w_force_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lat_cnt  <= 2'd0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_wr_ack   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_we   <= 1'b0;
      r_ram_din  <= '0;
      r_leer_ram <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_wr_ack   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rd_grant) begin
            r_state    <= S_RD;
            r_ram_addr <= rd_addr;
            r_ram_we   <= 1'b0;
            r_leer_ram <= 1'b1;
          end else if (wr_req) begin
            r_state    <= S_WR;
            r_ram_addr <= wr_addr;
            r_ram_din  <= wr_data;
            r_ram_we   <= 1'b1;
            r_wr_ack   <= 1'b1;
          end
        end
        S_RD: begin
          r_lat_cnt <= LAT_INIT;
          r_state   <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          // RAM output is sampled once its latency has elapsed since the address went out.
          if (r_lat_cnt == 2'd0) begin
            r_rd_data  <= ram_dout;
            r_rd_valid <= 1'b1;
            r_leer_ram <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_lat_cnt <= r_lat_cnt - 2'd1;
          end
        end
        S_WR: begin
          r_ram_we <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign wr_ack   = r_wr_ack;
  assign ram_addr = r_ram_addr;
  assign ram_we   = r_ram_we;
  assign ram_din  = r_ram_din;
  assign leer_ram = r_leer_ram;

endmodule

// File: tb/tb_ram_port_sched.sv
// Directed self-checking bench for ram_port_sched with a 1-cycle synchronous RAM model.
module tb_ram_port_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic [7:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic       leer_ram;

  logic [7:0] mem [256];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_port_sched #(.AW(8), .DW(8), .RD_LAT(1), .MAX_RD_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .leer_ram(leer_ram)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {4'd0, rd_valid, rd_data, wr_ack, ram_addr, ram_we, ram_din, leer_ram};
  endfunction

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    int n;
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    n = 0;
    while (n < 10) begin
      @(negedge clk); n++;
      if (wr_ack) break;
    end
    chk("wr_lat", n, 1);
    chk("wr_we", ram_we, 1'b1);
    chk("wr_addr", ram_addr, a);
    chk("wr_din", ram_din, d);
    wr_req = 1'b0;
    @(negedge clk);
    chk("wr_we_clr", {ram_we, wr_ack}, 2'b00);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] exp);
    int n;
    rd_req = 1'b1; rd_addr = a;
    n = 0;
    while (n < 10) begin
      @(negedge clk); n++;
      if (rd_valid) break;
      chk("rd_leer", leer_ram, 1'b1);
    end
    chk("rd_lat", n, 3);
    chk("rd_data", rd_data, exp);
    chk("rd_leer_clr", leer_ram, 1'b0);
    rd_req = 1'b0;
    @(negedge clk);
    chk("rd_valid_pulse", rd_valid, 1'b0);
  endtask

  initial begin
    int nrd, nack, rv_at, wa_at;
    logic resumed, saw_ack;
    rst = 1'b1; rd_req = 1'b0; rd_addr = 8'h00;
    wr_req = 1'b1; wr_addr = 8'h55; wr_data = 8'h11;

    // reset held with a write pending: everything stays quiet
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outs", outs(), 32'd0);
    end
    rst = 1'b0; wr_req = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", outs(), 32'd0);

    do_write(8'h10, 8'hA5);
    do_write(8'h2C, 8'h5A);
    do_read(8'h10, 8'hA5);
    do_write(8'hFF, 8'h3C);
    do_read(8'hFF, 8'h3C);

    // simultaneous requests: read first, write in the next slot
    rd_req = 1'b1; rd_addr = 8'h10;
    wr_req = 1'b1; wr_addr = 8'h20; wr_data = 8'h77;
    rv_at = 0; wa_at = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (rd_valid) begin
        rv_at = n; chk("both_rd_data", rd_data, 8'hA5); rd_req = 1'b0;
      end
      if (wr_ack) begin
        wa_at = n; chk("both_wr_addr", ram_addr, 8'h20); wr_req = 1'b0;
        break;
      end
    end
    chk("both_rd_at", rv_at, 3);
    chk("both_wr_at", wa_at, 4);
    @(negedge clk);
    do_read(8'h20, 8'h77);

    // continuous reads with a waiting write
    rd_req = 1'b1; rd_addr = 8'h10;
    wr_req = 1'b1; wr_addr = 8'h30; wr_data = 8'hC3;
    nrd = 0; nack = 0;
`ifdef POV_SCHED_STARVE_GUARD_EN
    saw_ack = 1'b0; resumed = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (rd_valid) begin
        if (saw_ack) begin
          resumed = 1'b1; rd_req = 1'b0;
          break;
        end
        nrd++;
      end
      if (wr_ack) begin
        saw_ack = 1'b1; wr_req = 1'b0;
      end
    end
    chk("guard_rd_grants", nrd, 4);
    chk("guard_wr_ack", saw_ack, 1'b1);
    chk("guard_rd_resume", resumed, 1'b1);
    chk("guard_rd_data", rd_data, 8'hA5);
`else
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (rd_valid) nrd++;
      if (wr_ack) nack++;
    end
    chk("strict_no_ack", nack, 0);
    chk("strict_reads", nrd >= 8, 1'b1);
    chk("strict_rd_data", rd_data, 8'hA5);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (rd_valid) begin
        rd_req = 1'b0;
        break;
      end
    end
    @(negedge clk);
    chk("strict_ack_after_drop", wr_ack, 1'b1);
    wr_req = 1'b0;
`endif
    @(negedge clk);
    do_read(8'h30, 8'hC3);

    // reset while the read is waiting on the RAM
    rd_req = 1'b1; rd_addr = 8'h2C;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_leer", leer_ram, 1'b1);
    rst = 1'b1; rd_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_mid_outs", outs(), 32'd0);
    end
    rst = 1'b0;
    nrd = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rd_valid) nrd++;
    end
    chk("rst_mid_no_valid", nrd, 0);
    do_read(8'h2C, 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
